// File: rtl/stage_mem_ls.sv
// stage_mem_ls: MEM pipeline stage for a req/addr_ok/data_ok data-SRAM interface.
//
// Holds one instruction handed over by EX. If EX already issued a data request
// for it, the stage waits for data_ok. A load response is aligned and
// sign/zero-extended here. Stores only wait for the response. The result is
// offered to WB through a valid/allow handshake.
//
// A flush cancels the held instruction. If that instruction's response is
// still outstanding, the stage remembers to swallow the next data_ok, so the
// stale response cannot be credited to a later instruction.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   validin / allowin         handshake with EX
//   validout / allowout       handshake with WB
//   flush                     cancel held instruction
//   input_*                   instruction payload from EX
//   data_sram_data_ok/rdata   data-SRAM response channel
//   output_*                  write-back payload to WB
//   fwd_*                     bypass information for ID
module stage_mem_ls #(
    parameter int DATA_W = 32,
    parameter int RF_AW  = 5,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              validin,
    output logic              allowin,
    output logic              validout,
    input  logic              allowout,
    input  logic              flush,
    input  logic [PC_W-1:0]   input_pc,
    input  logic              input_rf_we,
    input  logic [RF_AW-1:0]  input_rf_waddr,
    input  logic              input_mem_req,
    input  logic              input_mem_read,
    input  logic [2:0]        input_mem_op,
    input  logic [DATA_W-1:0] input_alu_result,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    output logic [PC_W-1:0]   output_pc,
    output logic              output_rf_we,
    output logic [RF_AW-1:0]  output_rf_waddr,
    output logic [DATA_W-1:0] output_rf_wdata,
    output logic              fwd_valid,
    output logic [RF_AW-1:0]  fwd_waddr,
    output logic              fwd_data_ready
);

    localparam int OFF_W = $clog2(DATA_W / 8);

    logic              valid_reg;
    logic              resp_got_reg;
    logic              drop_pending_reg;
    logic [PC_W-1:0]   pc_reg;
    logic              rf_we_reg;
    logic [RF_AW-1:0]  waddr_reg;
    logic              mem_req_reg;
    logic              mem_read_reg;
    logic [2:0]        mem_op_reg;
    logic [DATA_W-1:0] alu_result_reg;
    logic [DATA_W-1:0] rdata_buf_reg;

    logic              readygo;
    logic              capture;
    logic              leave;
    logic              buffer_resp;
    logic [DATA_W-1:0] raw;
    logic [OFF_W-1:0]  off;
    logic [7:0]        sel_b;
    logic [15:0]       sel_h;
    logic [31:0]       sel_w;
    logic [DATA_W-1:0] load_ext;

    // A response that arrives while a drop is pending belongs to a flushed
    // instruction, so it never completes the current one.
    assign readygo  = !mem_req_reg || resp_got_reg || (data_sram_data_ok && !drop_pending_reg);
    assign validout = valid_reg && readygo;
    assign allowin  = !(drop_pending_reg && !data_sram_data_ok)
                      && (!valid_reg || (readygo && allowout));
    assign capture  = validin && allowin && !flush;
    assign leave    = validout && allowout;

    // Park the response only when it cannot be handed to WB in the same cycle.
    assign buffer_resp = valid_reg && mem_req_reg && !resp_got_reg && !drop_pending_reg
                         && data_sram_data_ok && !allowout;

    assign raw = resp_got_reg ? rdata_buf_reg : data_sram_rdata;
    assign off = alu_result_reg[OFF_W-1:0];

    // Low address bits inside the access size are dropped, so misaligned
    // addresses round down to the containing half/word.
    assign sel_b = raw[{off, 3'b000} +: 8];
    assign sel_h = raw[{off[OFF_W-1:1], 4'b0000} +: 16];

    generate
        if (DATA_W == 64) begin : g_word64
            assign sel_w = raw[{off[OFF_W-1], 5'b00000} +: 32];
        end else begin : g_word32
            assign sel_w = raw[31:0];
        end
    endgenerate

    always_comb begin
        load_ext = raw;
        case (mem_op_reg[1:0])
            2'd0: load_ext = mem_op_reg[2] ? DATA_W'(sel_b) : DATA_W'(signed'(sel_b));
            2'd1: load_ext = mem_op_reg[2] ? DATA_W'(sel_h) : DATA_W'(signed'(sel_h));
            2'd2: load_ext = mem_op_reg[2] ? DATA_W'(sel_w) : DATA_W'(signed'(sel_w));
            default: load_ext = raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg        <= 1'b0;
            resp_got_reg     <= 1'b0;
            drop_pending_reg <= 1'b0;
            pc_reg           <= '0;
            rf_we_reg        <= 1'b0;
            waddr_reg        <= '0;
            mem_req_reg      <= 1'b0;
            mem_read_reg     <= 1'b0;
            mem_op_reg       <= '0;
            alu_result_reg   <= '0;
            rdata_buf_reg    <= '0;
        end else begin
            // The stale response is swallowed on the edge it arrives.
            if (drop_pending_reg && data_sram_data_ok) begin
                drop_pending_reg <= 1'b0;
            end

            if (flush) begin
                valid_reg    <= 1'b0;
                resp_got_reg <= 1'b0;
                if (valid_reg && mem_req_reg && !resp_got_reg && !data_sram_data_ok) begin
                    drop_pending_reg <= 1'b1;
                end
            end else begin
                if (buffer_resp) begin
                    rdata_buf_reg <= data_sram_rdata;
                    resp_got_reg  <= 1'b1;
                end
                if (capture) begin
                    valid_reg      <= 1'b1;
                    resp_got_reg   <= 1'b0;
                    pc_reg         <= input_pc;
                    rf_we_reg      <= input_rf_we;
                    waddr_reg      <= input_rf_waddr;
                    mem_req_reg    <= input_mem_req;
                    mem_read_reg   <= input_mem_read;
                    mem_op_reg     <= input_mem_op;
                    alu_result_reg <= input_alu_result;
                end else if (leave) begin
                    valid_reg <= 1'b0;
                end
            end
        end
    end

    assign output_pc       = pc_reg;
    assign output_rf_we    = valid_reg && rf_we_reg;
    assign output_rf_waddr = waddr_reg;
    assign output_rf_wdata = mem_read_reg ? load_ext : alu_result_reg;

    assign fwd_valid      = valid_reg && rf_we_reg && (waddr_reg != '0);
    assign fwd_waddr      = waddr_reg;
    assign fwd_data_ready = fwd_valid && (!mem_read_reg || readygo);

endmodule

// File: tb/tb_stage_mem_ls.sv
// tb_stage_mem_ls: directed bench for stage_mem_ls, with a 32-bit instance and a 64-bit instance.
// Inputs change 1 time unit after the rising edge. Outputs are checked 1 time
// unit later, which is still inside the same cycle.
module tb_stage_mem_ls;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 32-bit instance signals
    logic        validin, allowin, validout, allowout, flush;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  waddr;
    logic        mem_req, mem_read;
    logic [2:0]  mem_op;
    logic [31:0] alu, rdata;
    logic        data_ok;
    logic [31:0] o_pc, o_wdata;
    logic        o_we;
    logic [4:0]  o_waddr, f_waddr;
    logic        f_valid, f_ready;

    // 64-bit instance signals
    logic        validin64, allowin64, validout64, allowout64, flush64;
    logic [31:0] pc64;
    logic        rf_we64;
    logic [4:0]  waddr64;
    logic        mem_req64, mem_read64;
    logic [2:0]  mem_op64;
    logic [63:0] alu64, rdata64;
    logic        data_ok64;
    logic [31:0] o_pc64;
    logic [63:0] o_wdata64;
    logic        o_we64;
    logic [4:0]  o_waddr64, f_waddr64;
    logic        f_valid64, f_ready64;

    int pass_cnt = 0;
    int total_cnt = 0;

    stage_mem_ls #(.DATA_W(32), .RF_AW(5), .PC_W(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .validin(validin), .allowin(allowin), .validout(validout), .allowout(allowout),
        .flush(flush), .input_pc(pc), .input_rf_we(rf_we), .input_rf_waddr(waddr),
        .input_mem_req(mem_req), .input_mem_read(mem_read), .input_mem_op(mem_op),
        .input_alu_result(alu), .data_sram_data_ok(data_ok), .data_sram_rdata(rdata),
        .output_pc(o_pc), .output_rf_we(o_we), .output_rf_waddr(o_waddr),
        .output_rf_wdata(o_wdata), .fwd_valid(f_valid), .fwd_waddr(f_waddr),
        .fwd_data_ready(f_ready)
    );

    stage_mem_ls #(.DATA_W(64), .RF_AW(5), .PC_W(32)) u_dut64 (
        .clk(clk), .rst(rst),
        .validin(validin64), .allowin(allowin64), .validout(validout64), .allowout(allowout64),
        .flush(flush64), .input_pc(pc64), .input_rf_we(rf_we64), .input_rf_waddr(waddr64),
        .input_mem_req(mem_req64), .input_mem_read(mem_read64), .input_mem_op(mem_op64),
        .input_alu_result(alu64), .data_sram_data_ok(data_ok64), .data_sram_rdata(rdata64),
        .output_pc(o_pc64), .output_rf_we(o_we64), .output_rf_waddr(o_waddr64),
        .output_rf_wdata(o_wdata64), .fwd_valid(f_valid64), .fwd_waddr(f_waddr64),
        .fwd_data_ready(f_ready64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ins(input logic [31:0] p, input logic we, input logic [4:0] wa,
                           input logic req, input logic rd, input logic [2:0] op,
                           input logic [31:0] a);
        validin  = 1'b1;
        pc       = p;
        rf_we    = we;
        waddr    = wa;
        mem_req  = req;
        mem_read = rd;
        mem_op   = op;
        alu      = a;
    endtask

    task automatic set_ins64(input logic [31:0] p, input logic [2:0] op, input logic [63:0] a);
        validin64  = 1'b1;
        pc64       = p;
        rf_we64    = 1'b1;
        waddr64    = 5'd3;
        mem_req64  = 1'b1;
        mem_read64 = 1'b1;
        mem_op64   = op;
        alu64      = a;
    endtask

    initial begin
        rst = 1'b1;
        validin = 0; allowout = 0; flush = 0; pc = 0; rf_we = 0; waddr = 0;
        mem_req = 0; mem_read = 0; mem_op = 0; alu = 0; data_ok = 0; rdata = 0;
        validin64 = 0; allowout64 = 0; flush64 = 0; pc64 = 0; rf_we64 = 0; waddr64 = 0;
        mem_req64 = 0; mem_read64 = 0; mem_op64 = 0; alu64 = 0; data_ok64 = 0; rdata64 = 0;

        // Reset state
        tick();
        rst = 1'b0;
        #1;
        chk("rst_validout", validout, 0);
        chk("rst_allowin", allowin, 1);
        chk("rst_pc", o_pc, 0);
        chk("rst_wdata", o_wdata, 0);
        chk("rst_we", o_we, 0);
        chk("rst_fwd_valid", f_valid, 0);

        // ALU ops back to back
        allowout = 1'b1;
        set_ins(32'h100, 1, 5'd5, 0, 0, 3'b000, 32'h12345678);
        tick();
        set_ins(32'h104, 1, 5'd6, 0, 0, 3'b000, 32'hCAFEBABE);
        #1;
        chk("alu1_validout", validout, 1);
        chk("alu1_wdata", o_wdata, 32'h12345678);
        chk("alu1_waddr", o_waddr, 5);
        chk("alu1_allowin", allowin, 1);
        chk("alu1_fwd_ready", f_ready, 1);
        tick();
        validin = 1'b0;
        #1;
        chk("alu2_validout", validout, 1);
        chk("alu2_wdata", o_wdata, 32'hCAFEBABE);
        chk("alu2_pc", o_pc, 32'h104);
        tick();
        chk("alu_drain_validout", validout, 0);
        chk("alu_drain_we", o_we, 0);

        // Signed byte load at 0x1003, data_ok three cycles after capture
        set_ins(32'h108, 1, 5'd7, 1, 1, 3'b000, 32'h1003);
        tick();
        validin = 1'b0;
        #1;
        chk("lb_wait_validout", validout, 0);
        chk("lb_wait_allowin", allowin, 0);
        chk("lb_wait_fwd_valid", f_valid, 1);
        chk("lb_wait_fwd_ready", f_ready, 0);
        chk("lb_wait_fwd_waddr", f_waddr, 7);
        tick();
        chk("lb_wait2_validout", validout, 0);
        tick();
        data_ok = 1'b1;
        rdata = 32'h80FF0000;
        #1;
        chk("lb_validout", validout, 1);
        chk("lb_wdata", o_wdata, 32'hFFFFFF80);
        chk("lb_fwd_ready", f_ready, 1);
        tick();
        data_ok = 1'b0;

        // Unsigned byte load, same address and data
        set_ins(32'h10C, 1, 5'd7, 1, 1, 3'b100, 32'h1003);
        tick();
        validin = 1'b0;
        data_ok = 1'b1;
        #1;
        chk("lbu_wdata", o_wdata, 32'h00000080);
        chk("lbu_validout", validout, 1);
        tick();
        data_ok = 1'b0;

        // Signed half load buffered while WB stalls
        allowout = 1'b0;
        set_ins(32'h110, 1, 5'd8, 1, 1, 3'b001, 32'h2002);
        tick();
        validin = 1'b0;
        data_ok = 1'b1;
        rdata = 32'h80011234;
        #1;
        chk("lh_ok_validout", validout, 1);
        chk("lh_ok_allowin", allowin, 0);
        tick();
        data_ok = 1'b0;
        rdata = 32'hDEADBEEF;
        #1;
        chk("lh_buf_validout", validout, 1);
        chk("lh_buf_wdata", o_wdata, 32'hFFFF8001);
        tick();
        allowout = 1'b1;
        rdata = 32'h00000000;
        #1;
        chk("lh_rel_validout", validout, 1);
        chk("lh_rel_wdata", o_wdata, 32'hFFFF8001);
        tick();
        chk("lh_done_validout", validout, 0);
        chk("lh_done_allowin", allowin, 1);

        // Store: waits for data_ok, result is the ALU value
        set_ins(32'h114, 0, 5'd0, 1, 0, 3'b010, 32'h00000077);
        tick();
        validin = 1'b0;
        #1;
        chk("st_wait_validout", validout, 0);
        tick();
        data_ok = 1'b1;
        #1;
        chk("st_validout", validout, 1);
        chk("st_wdata", o_wdata, 32'h77);
        tick();
        data_ok = 1'b0;

        // Flush during an outstanding load; the next data_ok is dropped
        set_ins(32'h118, 1, 5'd9, 1, 1, 3'b010, 32'h3000);
        tick();
        validin = 1'b0;
        flush = 1'b1;
        #1;
        chk("fl_cycle_validout", validout, 0);
        tick();
        flush = 1'b0;
        set_ins(32'h200, 1, 5'd10, 0, 0, 3'b000, 32'h55);
        #1;
        chk("fl_validout", validout, 0);
        chk("fl_allowin", allowin, 0);
        chk("fl_we", o_we, 0);
        chk("fl_fwd_valid", f_valid, 0);
        tick();
        chk("fl_hold_pc", o_pc, 32'h118);
        data_ok = 1'b1;
        rdata = 32'h11111111;
        #1;
        chk("fl_drop_allowin", allowin, 1);
        chk("fl_drop_validout", validout, 0);
        tick();
        data_ok = 1'b0;
        validin = 1'b0;
        #1;
        chk("fl_next_validout", validout, 1);
        chk("fl_next_wdata", o_wdata, 32'h55);
        chk("fl_next_pc", o_pc, 32'h200);
        tick();

        // waddr 0 never forwards
        set_ins(32'h204, 1, 5'd0, 0, 0, 3'b000, 32'h66);
        tick();
        validin = 1'b0;
        #1;
        chk("r0_validout", validout, 1);
        chk("r0_fwd_valid", f_valid, 0);
        tick();

        // Reset in the middle of a wait; a stale data_ok is then ignored
        set_ins(32'h300, 1, 5'd11, 1, 1, 3'b010, 32'h4000);
        tick();
        validin = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mrst_validout", validout, 0);
        chk("mrst_allowin", allowin, 1);
        chk("mrst_pc", o_pc, 0);
        chk("mrst_we", o_we, 0);
        chk("mrst_wdata", o_wdata, 0);
        data_ok = 1'b1;
        rdata = 32'h99;
        #1;
        chk("mrst_stale_validout", validout, 0);
        chk("mrst_stale_allowin", allowin, 1);
        tick();
        data_ok = 1'b0;
        set_ins(32'h304, 1, 5'd12, 0, 0, 3'b000, 32'hABCD);
        tick();
        validin = 1'b0;
        #1;
        chk("mrst_next_wdata", o_wdata, 32'hABCD);
        chk("mrst_next_validout", validout, 1);
        tick();

        // 64-bit instance: D, signed W, unsigned W loads
        allowout64 = 1'b1;
        set_ins64(32'h400, 3'b011, 64'h8);
        tick();
        validin64 = 1'b0;
        data_ok64 = 1'b1;
        rdata64 = 64'h0123456789ABCDEF;
        #1;
        chk("ld64_validout", validout64, 1);
        chk("ld64_wdata", o_wdata64, 64'h0123456789ABCDEF);
        tick();
        data_ok64 = 1'b0;
        set_ins64(32'h404, 3'b010, 64'h4);
        tick();
        validin64 = 1'b0;
        data_ok64 = 1'b1;
        rdata64 = 64'h80000000_12345678;
        #1;
        chk("lw64_wdata", o_wdata64, 64'hFFFFFFFF80000000);
        tick();
        data_ok64 = 1'b0;
        set_ins64(32'h408, 3'b110, 64'h4);
        tick();
        validin64 = 1'b0;
        data_ok64 = 1'b1;
        #1;
        chk("lwu64_wdata", o_wdata64, 64'h0000000080000000);
        tick();
        data_ok64 = 1'b0;
        set_ins64(32'h40C, 3'b000, 64'h6);
        tick();
        validin64 = 1'b0;
        data_ok64 = 1'b1;
        rdata64 = 64'h00F1000000000000;
        #1;
        chk("lb64_wdata", o_wdata64, 64'hFFFFFFFFFFFFFFF1);
        tick();
        data_ok64 = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/stage_mem_ls.md
Name: stage_mem_ls

Overview:
Parametrised MEM pipeline stage for the data-SRAM-like (req/addr_ok/data_ok) interface. It holds one instruction from EX and waits a variable number of cycles for the data response of a load or store issued in EX. It performs byte/half/word(/dword) load alignment with sign or zero extension and presents the write-back payload to WB. It supports a flush that cancels the held instruction while correctly discarding an in-flight response, and it exports bypass information to ID.

Parameters:
DATA_W, 32, datapath width; legal 32 or 64; byte lanes = DATA_W/8
RF_AW, 5, register-file address width
PC_W, 32, width of trace PC

Ports:
clk  in  1  clock
rst  in  1  reset
validin  in  1  EX holds a valid instruction
allowin  out  1  stage can accept this cycle
validout  out  1  instruction complete, offered to WB
allowout  in  1  WB accepts
flush  in  1  cancel held instruction (exception/ertn)
input_pc  in  PC_W  trace PC
input_rf_we  in  1  write-back enable
input_rf_waddr  in  RF_AW  destination register
input_mem_req  in  1  EX issued a data request (addr_ok seen) for this instruction
input_mem_read  in  1  instruction is a load
input_mem_op  in  3  [1:0] size 0=B,1=H,2=W,3=D (D legal only if DATA_W=64); [2]=unsigned
input_alu_result  in  DATA_W  address for loads, result otherwise
data_sram_data_ok  in  1  response valid
data_sram_rdata  in  DATA_W  response data (full aligned word)
output_pc  out  PC_W  held PC
output_rf_we  out  1  held we, gated by valid
output_rf_waddr  out  RF_AW  held waddr
output_rf_wdata  out  DATA_W  write-back data
fwd_valid  out  1  valid && rf_we && waddr!=0
fwd_waddr  out  RF_AW  = output_rf_waddr
fwd_data_ready  out  1  fwd_valid && (!mem_read || readygo)

Behaviour:
- Reset (clk edge with rst=1): valid, resp_got, drop_pending, all held regs and rdata buffer = 0. All outputs are therefore 0, and allowin=1.
- Capture: on validin && allowin, latch pc, rf_we, waddr, mem_req, mem_read, mem_op, alu_result; set valid=1; clear resp_got.
- readygo = !mem_req || resp_got || (data_ok && !drop_pending).
- validout = valid && readygo.
- allowin = !(drop_pending && !data_ok) && (!valid || (readygo && allowout)).
- The instruction leaves on validout && allowout. valid becomes 0 unless a new capture happens in the same cycle (back-to-back, no bubble).
- Response buffering: data_ok arrives while valid && mem_req && !resp_got && !drop_pending but allowout=0 -> store rdata in buffer, resp_got=1. Later cycles use the buffer. Raw data = resp_got ? buffer : data_sram_rdata.
- Load alignment: offset = alu_result[log2(DATA_W/8)-1:0].
  - B selects byte[offset].
  - H selects halfword[offset>>1].
  - W selects word[offset>>2] (64-bit only).
  - D selects the whole word.
  - Extension: bit 2 of mem_op=0 -> sign-extend to DATA_W; =1 -> zero-extend.
  - Misaligned low bits inside the size are ignored, i.e. truncated.
  - output_rf_wdata = mem_read ? extended : alu_result.
- Stores (mem_req && !mem_read) also wait for data_ok; wdata = alu_result.
- Flush (priority over capture and leave):
  - Sets valid=0.
  - If valid && mem_req && !resp_got && !data_ok that cycle, set drop_pending=1.
  - While drop_pending=1, the next data_ok is consumed and discarded. drop_pending clears on that edge, and capture is allowed in the same cycle.
  - validin is ignored in a flush cycle.
- data_ok when there is no outstanding request and no drop_pending: ignored.
- output_rf_we = valid && rf_we. WB must only sample it when validout=1.

Test Plan:
- Non-memory ALU op: alu_result=0x12345678, rf_we=1, waddr=5 -> validout the cycle after capture, wdata=0x12345678. Back-to-back with allowout=1 gives 1 instruction/cycle.
- Load byte signed: addr=0x1003, rdata=0x80FF_0000, data_ok 3 cycles after capture -> validout only in the data_ok cycle, wdata=0xFFFFFF80. The same case with unsigned gives 0x00000080.
- Load half at addr 0x...2, rdata=0x8001_xxxx, data_ok while allowout=0 -> response buffered. When allowout rises 2 cycles later, wdata=0xFFFF8001. data_sram_rdata changes meanwhile have no effect.
- Flush during outstanding load -> valid=0, allowin=0 until the next data_ok. That data_ok is dropped (no validout). The next instruction then captures and completes normally.
- Forwarding: a load to r7 before data_ok gives fwd_valid=1, fwd_data_ready=0; in the data_ok cycle fwd_data_ready=1. waddr=0 gives fwd_valid=0.
- DATA_W=64 build: D load at addr 0x8 returns full rdata. Signed W at offset 4 with rdata[63:32]=0x80000000 gives 0xFFFFFFFF80000000.
- Reset asserted mid-wait -> all outputs 0 next cycle, allowin=1, and a stale data_ok afterwards is ignored.
